// File: rtl/dj8_extmem_seq.sv
// rtl/dj8_extmem_seq.sv - dj8 external-memory bus sequencer (addr hi/lo, wait states, data phase)
module dj8_extmem_seq #(
   parameter int ADDR_W   = 16,
   parameter int WAIT_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_we,
   input  logic [7:0]        req_wdata,
   output logic              rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic [7:0]        mem_ad_out,
   input  logic [7:0]        mem_d_in,
   output logic [7:0]        mem_d_out,
   output logic [7:0]        mem_d_oe,
   output logic              mem_ale_hi,
   output logic              mem_ale_lo,
   output logic              mem_we_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_WAIT,
      S_DATA
   } state_t;

   // WAIT lasts WAIT_CYC cycles: counter starts at WAIT_CYC-1 and leaves on zero
   localparam bit         HAS_WAIT  = (WAIT_CYC > 0);
   localparam logic [2:0] WAIT_LOAD = HAS_WAIT ? 3'(WAIT_CYC - 1) : 3'd0;

   state_t      state_q;
   logic [15:0] addr_q;
   logic        we_q;
   logic [7:0]  wdata_q;
   logic [2:0]  cnt_q;
   logic        ready_q;
   logic        rsp_valid_q;
   logic [7:0]  rdata_q;
   logic [7:0]  ad_q;
   logic        ale_hi_q;
   logic        ale_lo_q;
   logic        we_n_q;
   logic [7:0]  d_out_q;
   logic [7:0]  oe_q;

   // Narrow CPU addresses are zero-padded to the full 16-bit bus address
   logic [15:0] addr_pad_d;
   assign addr_pad_d = 16'(req_addr);

   // Sequencer FSM; every bus output is registered against the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         ad_q        <= '0;
         ale_hi_q    <= 1'b0;
         ale_lo_q    <= 1'b0;
         we_n_q      <= 1'b1;
         d_out_q     <= '0;
         oe_q        <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         ale_hi_q    <= 1'b0;
         ale_lo_q    <= 1'b0;
         we_n_q      <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (req_valid && ready_q) begin
                  addr_q   <= addr_pad_d;
                  we_q     <= req_we;
                  wdata_q  <= req_wdata;
                  ready_q  <= 1'b0;
                  ad_q     <= addr_pad_d[15:8];
                  ale_hi_q <= 1'b1;
                  state_q  <= S_ADDR_HI;
               end else begin
                  ad_q <= 8'h00;
               end
            end
            S_ADDR_HI: begin
               ad_q     <= addr_q[7:0];
               ale_lo_q <= 1'b1;
               state_q  <= S_ADDR_LO;
            end
            S_ADDR_LO: begin
               // Write data goes onto the pads from the first cycle after ADDR_LO
               if (we_q) begin
                  d_out_q <= wdata_q;
                  oe_q    <= 8'hFF;
               end
               if (HAS_WAIT) begin
                  cnt_q   <= WAIT_LOAD;
                  state_q <= S_WAIT;
               end else begin
                  we_n_q  <= ~we_q;
                  state_q <= S_DATA;
               end
            end
            S_WAIT: begin
               if (cnt_q == 3'd0) begin
                  we_n_q  <= ~we_q;
                  state_q <= S_DATA;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_DATA: begin
               if (!we_q) begin
                  rdata_q <= mem_d_in;
               end
               ad_q        <= 8'h00;
               d_out_q     <= 8'h00;
               oe_q        <= 8'h00;
               ready_q     <= 1'b1;
               rsp_valid_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               ad_q    <= 8'h00;
               oe_q    <= 8'h00;
               d_out_q <= 8'h00;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rdata_q;
   assign mem_ad_out = ad_q;
   assign mem_ale_hi = ale_hi_q;
   assign mem_ale_lo = ale_lo_q;
   assign mem_we_n   = we_n_q;
   assign mem_d_out  = d_out_q;
   assign mem_d_oe   = oe_q;

endmodule
